// File: rtl/multi_switch_controller.sv
// Memory-mapped debounced input controller: synchronises and debounces an NIN-bit
// input vector and queues every committed change in a small event FIFO for the CPU.
module multi_switch_controller #(
  parameter int                DBITS          = 32,
  parameter int                NIN            = 10,
  parameter logic [DBITS-1:0]  DATA_ADDR      = DBITS'(32'hF000_0014),
  parameter logic [DBITS-1:0]  CTRL_ADDR      = DBITS'(32'hF000_0114),
  parameter int                DEBOUNCE_COUNT = 100000,
  parameter int                DEPTH          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrtEn,
  input  logic [DBITS-1:0] address,
  inout  wire  [DBITS-1:0] dbus,
  input  logic [NIN-1:0]   switches,
  output logic             intr
);

  localparam int CNT_W = $clog2(DEBOUNCE_COUNT) + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_COUNT - 1);

  logic [NIN-1:0]   sync1, sync2, cand, stable;
  logic [CNT_W-1:0] cnt;

  logic [NIN-1:0]   mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             overrun, ie;

  logic             rd_data, rd_ctrl, wr_ctrl;
  logic             ready, full, commit, pop, push, drop;
  logic [DBITS-1:0] data_word, ctrl_word;
  logic             unused_bits;

  // Bus decode
  assign rd_data = !wrtEn && (address == DATA_ADDR);
  assign rd_ctrl = !wrtEn && (address == CTRL_ADDR);
  assign wr_ctrl =  wrtEn && (address == CTRL_ADDR);

  assign ready  = (count != '0);
  assign full   = (count == CW'(DEPTH));
  assign commit = (sync2 == cand) && (cnt == CNT_MAX) && (cand != stable);
  assign pop    = rd_data && ready;
  // A pop on the commit edge frees a slot, so a full FIFO still accepts the push.
  assign push   = commit && (!full || pop);
  assign drop   = commit && full && !pop;

  assign intr = ie && ready;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= '0;
      sync2  <= '0;
      cand   <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      sync1 <= switches;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        if (cand != stable) stable <= cand;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // NOTE: the snapshot storage has no reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cand;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A dropped snapshot in the same cycle as a clear write keeps overrun set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
      ie      <= 1'b0;
    end else begin
      if (drop)                        overrun <= 1'b1;
      else if (wr_ctrl && !dbus[2])    overrun <= 1'b0;
      if (wr_ctrl)                     ie      <= dbus[4];
    end
  end

  // NOTE: every always_comb output gets a full default first, so no latch can be inferred.
  always_comb begin
    data_word          = '0;
    data_word[NIN-1:0] = ready ? mem[rd_ptr] : stable;
    ctrl_word          = '0;
    ctrl_word[8 +: CW] = count;
    ctrl_word[4]       = ie;
    ctrl_word[2]       = overrun;
    ctrl_word[0]       = ready;
  end

  assign dbus = rd_data ? data_word :
                rd_ctrl ? ctrl_word : {DBITS{1'bz}};

  assign unused_bits = ^{dbus[DBITS-1:5], dbus[3], dbus[1:0]};

endmodule

// File: tb/tb_multi_switch_controller.sv
// Directed bench for multi_switch_controller with DEBOUNCE_COUNT=4, DEPTH=4, NIN=10.
module tb_multi_switch_controller;

  localparam logic [31:0] DATA_A = 32'hF000_0014;
  localparam logic [31:0] CTRL_A = 32'hF000_0114;
  localparam logic [31:0] IDLE_A = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        wrtEn;
  logic [31:0] address;
  logic [9:0]  switches;
  logic        intr;
  wire  [31:0] dbus;
  logic        drv;
  logic [31:0] wdata;

  int n_cmp = 0;
  int n_err = 0;

  assign dbus = drv ? wdata : 32'hzzzz_zzzz;

  always #5 clk = ~clk;

  multi_switch_controller #(
    .DBITS(32), .NIN(10), .DATA_ADDR(DATA_A), .CTRL_ADDR(CTRL_A),
    .DEBOUNCE_COUNT(4), .DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .wrtEn(wrtEn), .address(address),
    .dbus(dbus), .switches(switches), .intr(intr)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle read: sample mid-cycle, then cross exactly one rising edge.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    address = a;
    wrtEn   = 1'b0;
    #1 v = dbus;
    @(negedge clk);
    address = IDLE_A;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    address = a;
    wrtEn   = 1'b1;
    wdata   = d;
    drv     = 1'b1;
    @(negedge clk);
    wrtEn   = 1'b0;
    drv     = 1'b0;
    address = IDLE_A;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b0; wrtEn = 1'b0; address = IDLE_A; drv = 1'b0; wdata = '0;
    switches = 10'h155;
    cyc(3);
    #1;
    n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL reset_intr got %b expected 0", intr); end
    address = CTRL_A; #1 v = dbus;
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_ctrl got %h expected %h", v, 32'h0); end
    address = DATA_A; #1 v = dbus;
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_data got %h expected %h", v, 32'h0); end
    address = IDLE_A;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_first_event;
    logic [31:0] v;
    cyc(5);
    bus_read(CTRL_A, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL first_e4 got %h expected %h", v, 32'h0); end
    bus_read(CTRL_A, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL first_e5 got %h expected %h", v, 32'h0); end
    bus_read(CTRL_A, v);
    n_cmp++; if (v !== 32'h101) begin n_err++; $display("FAIL first_e6 got %h expected %h", v, 32'h101); end
    n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL first_intr got %b expected 0", intr); end
    bus_read(DATA_A, v);
    n_cmp++; if (v !== 32'h155) begin n_err++; $display("FAIL first_pop got %h expected %h", v, 32'h155); end
    bus_read(CTRL_A, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL first_empty got %h expected %h", v, 32'h0); end
    bus_read(DATA_A, v);
    n_cmp++; if (v !== 32'h155) begin n_err++; $display("FAIL first_stable got %h expected %h", v, 32'h155); end
  endtask

  task automatic test_bounce;
    logic [31:0] v;
    address = CTRL_A;
    for (int i = 0; i < 7; i++) begin
      switches = (i % 2 == 1) ? 10'h001 : 10'h000;
      cyc(3);
      #1 v = dbus;
      n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL bounce_seg%0d got %h expected %h", i, v, 32'h0); end
    end
    switches = 10'h001;
    cyc(5);
    #1 v = dbus;
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL bounce_e4 got %h expected %h", v, 32'h0); end
    cyc(1);
    #1 v = dbus;
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL bounce_e5 got %h expected %h", v, 32'h0); end
    cyc(1);
    #1 v = dbus;
    n_cmp++; if (v !== 32'h101) begin n_err++; $display("FAIL bounce_e6 got %h expected %h", v, 32'h101); end
    address = IDLE_A;
    @(negedge clk);
    bus_read(DATA_A, v);
    n_cmp++; if (v !== 32'h001) begin n_err++; $display("FAIL bounce_pop got %h expected %h", v, 32'h001); end
    bus_read(CTRL_A, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL bounce_single got %h expected %h", v, 32'h0); end
  endtask

  task automatic test_overflow;
    logic [31:0] v;
    logic [9:0]  vals [5] = '{10'h0A1, 10'h0A2, 10'h0A3, 10'h0A4, 10'h0A5};
    for (int i = 0; i < 5; i++) begin
      switches = vals[i];
      cyc(8);
    end
    bus_read(CTRL_A, v);
    n_cmp++; if (v !== 32'h405) begin n_err++; $display("FAIL ovf_ctrl got %h expected %h", v, 32'h405); end
    n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL ovf_intr got %b expected 0", intr); end
    for (int i = 0; i < 4; i++) begin
      bus_read(DATA_A, v);
      n_cmp++; if (v !== {22'h0, vals[i]}) begin n_err++; $display("FAIL ovf_pop%0d got %h expected %h", i, v, {22'h0, vals[i]}); end
    end
    bus_read(CTRL_A, v);
    n_cmp++; if (v !== 32'h004) begin n_err++; $display("FAIL ovf_sticky got %h expected %h", v, 32'h004); end
    bus_read(DATA_A, v);
    n_cmp++; if (v !== 32'h0A5) begin n_err++; $display("FAIL ovf_stable got %h expected %h", v, 32'h0A5); end
  endtask

  task automatic test_overrun_clear;
    logic [31:0] v;
    logic [9:0]  vals [4] = '{10'h0B1, 10'h0B2, 10'h0B3, 10'h0B4};
    bus_write(CTRL_A, 32'h4);
    bus_read(CTRL_A, v);
    n_cmp++; if (v !== 32'h004) begin n_err++; $display("FAIL clr_write1 got %h expected %h", v, 32'h004); end
    bus_write(CTRL_A, 32'h0);
    bus_read(CTRL_A, v);
    n_cmp++; if (v !== 32'h000) begin n_err++; $display("FAIL clr_write0 got %h expected %h", v, 32'h000); end
    for (int i = 0; i < 4; i++) begin
      switches = vals[i];
      cyc(8);
    end
    switches = 10'h0B5;
    cyc(6);
    bus_write(CTRL_A, 32'h0);
    bus_read(CTRL_A, v);
    n_cmp++; if (v !== 32'h405) begin n_err++; $display("FAIL clr_collide got %h expected %h", v, 32'h405); end
    for (int i = 0; i < 4; i++) begin
      bus_read(DATA_A, v);
      n_cmp++; if (v !== {22'h0, vals[i]}) begin n_err++; $display("FAIL clr_pop%0d got %h expected %h", i, v, {22'h0, vals[i]}); end
    end
    bus_write(CTRL_A, 32'h0);
    bus_read(CTRL_A, v);
    n_cmp++; if (v !== 32'h000) begin n_err++; $display("FAIL clr_final got %h expected %h", v, 32'h000); end
  endtask

  task automatic test_interrupt;
    logic [31:0] v;
    bus_write(CTRL_A, 32'h10);
    #1;
    n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL irq_empty got %b expected 0", intr); end
    bus_read(CTRL_A, v);
    n_cmp++; if (v !== 32'h010) begin n_err++; $display("FAIL irq_ctrl got %h expected %h", v, 32'h010); end
    switches = 10'h0C1;
    cyc(8);
    #1;
    n_cmp++; if (intr !== 1'b1) begin n_err++; $display("FAIL irq_raise got %b expected 1", intr); end
    bus_read(DATA_A, v);
    n_cmp++; if (v !== 32'h0C1) begin n_err++; $display("FAIL irq_pop got %h expected %h", v, 32'h0C1); end
    #1;
    n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL irq_drop got %b expected 0", intr); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    logic [9:0]  vals [5] = '{10'h0D1, 10'h0D2, 10'h0D3, 10'h0D4, 10'h0D5};
    for (int i = 0; i < 4; i++) begin
      switches = vals[i];
      cyc(8);
    end
    switches = vals[4];
    cyc(6);
    bus_read(DATA_A, v);
    n_cmp++; if (v !== 32'h0D1) begin n_err++; $display("FAIL b2b_head got %h expected %h", v, 32'h0D1); end
    bus_read(CTRL_A, v);
    n_cmp++; if (v !== 32'h411) begin n_err++; $display("FAIL b2b_ctrl got %h expected %h", v, 32'h411); end
    n_cmp++; if (intr !== 1'b1) begin n_err++; $display("FAIL b2b_intr got %b expected 1", intr); end
    for (int i = 1; i < 5; i++) begin
      bus_read(DATA_A, v);
      n_cmp++; if (v !== {22'h0, vals[i]}) begin n_err++; $display("FAIL b2b_wrap%0d got %h expected %h", i, v, {22'h0, vals[i]}); end
    end
    bus_read(CTRL_A, v);
    n_cmp++; if (v !== 32'h010) begin n_err++; $display("FAIL b2b_empty got %h expected %h", v, 32'h010); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    switches = 10'h0E0;
    cyc(8);
    switches = 10'h0E1;
    cyc(3);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL rst_intr got %b expected 0", intr); end
    address = CTRL_A; #1 v = dbus;
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_ctrl got %h expected %h", v, 32'h0); end
    address = DATA_A; #1 v = dbus;
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_data got %h expected %h", v, 32'h0); end
    address = IDLE_A;
    @(negedge clk);
    reset = 1'b1;
    cyc(7);
    bus_read(CTRL_A, v);
    n_cmp++; if (v !== 32'h101) begin n_err++; $display("FAIL rst_event got %h expected %h", v, 32'h101); end
    bus_read(DATA_A, v);
    n_cmp++; if (v !== 32'h0E1) begin n_err++; $display("FAIL rst_pop got %h expected %h", v, 32'h0E1); end
    bus_read(CTRL_A, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_once got %h expected %h", v, 32'h0); end
  endtask

  initial begin
    test_reset;
    test_first_event;
    test_bounce;
    test_overflow;
    test_overrun_clear;
    test_interrupt;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
